// File: rtl/ram8_burst_reader_pkg.sv
// Shared types and constants for the ram8 burst reader: FSM encoding, default widths,
// and the burst-length clamp.
package ram8_rdr_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 3;
    localparam int LEN_W     = 4;
    localparam int MAX_LEN   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A requested length beyond the memory depth reads every word exactly once.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/ram8_burst_reader_if.sv
// Bundle of command, memory-side and stream-side signals of the burst reader.
// The optional sum signal exists only when RAM8_RDR_CHECKSUM_EN is defined.
interface ram8_burst_reader_if #(
    parameter int WIDTH = ram8_rdr_pkg::DEF_WIDTH,
    parameter int AW    = ram8_rdr_pkg::DEF_AW
);
    import ram8_rdr_pkg::*;

    logic                 start;
    logic [AW-1:0]        base;
    logic [LEN_W-1:0]     len;
    logic [AW-1:0]        mem_add;
    logic                 mem_load;
    logic [WIDTH-1:0]     mem_o;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 busy;
    logic                 done;
    state_t               dbg_state;
`ifdef RAM8_RDR_CHECKSUM_EN
    logic [WIDTH-1:0]     sum;
`endif

    // Stream handshake: a word moves on a rising edge where dout_valid && dout_ready;
    // once raised, dout_valid and dout stay stable until that edge.
    modport master (
        input  start, base, len, mem_o, dout_ready,
        output mem_add, mem_load, dout, dout_valid, busy, done, dbg_state
`ifdef RAM8_RDR_CHECKSUM_EN
        , output sum
`endif
    );

    modport slave (
        output start, base, len, mem_o, dout_ready,
        input  mem_add, mem_load, dout, dout_valid, busy, done, dbg_state
`ifdef RAM8_RDR_CHECKSUM_EN
        , input sum
`endif
    );

endinterface

// File: rtl/ram8_burst_reader_addr_gen.sv
// Address generator for the burst reader: read pointer with modulo-depth wrap,
// remaining-word counter loaded from the clamped length, and the last-word flag.
module ram8_rdr_addr_gen
    import ram8_rdr_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [AW-1:0]    base_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             advance_i,
    output logic [AW-1:0]    ptr_o,
    output logic             last_o,
    output logic             empty_o
);

    logic [AW-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = clamp_len(len_i);
    assign empty_o     = (len_clamped == '0);
    assign last_o      = (rem_q == LEN_W'(1));
    assign ptr_o       = ptr_q;

    // The pointer stays on the final word so no extra address step follows the burst.
    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load_i) begin
            ptr_d = base_i;
            rem_d = len_clamped;
        end else if (advance_i) begin
            rem_d = rem_q - LEN_W'(1);
            if (!last_o) begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/ram8_burst_reader.sv
// Burst read engine for ram8: walks len words from base (wrapping), streams each over
// valid/ready, then pulses done. Optional checksum output under RAM8_RDR_CHECKSUM_EN.
module ram8_burst_reader
    import ram8_rdr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    ram8_burst_reader_if.master  bus
);

    state_t           state_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic [AW-1:0]    ptr;
    logic             last;
    logic             empty;
    logic             accept;
    logic             xfer;

    assign accept = (state_q == ST_IDLE) && bus.start;
    assign xfer   = (state_q == ST_SEND) && dout_valid_q && bus.dout_ready;

    ram8_rdr_addr_gen #(.AW(AW)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .base_i    (bus.base),
        .len_i     (bus.len),
        .advance_i (xfer),
        .ptr_o     (ptr),
        .last_o    (last),
        .empty_o   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= empty ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    dout_q       <= bus.mem_o;
                    dout_valid_q <= 1'b1;
                    state_q      <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= last ? ST_DONE : ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The address is held through SEND so the memory sees a steady value per word.
    assign bus.mem_add    = (state_q == ST_FETCH || state_q == ST_SEND) ? ptr : '0;
    assign bus.mem_load   = 1'b0;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.dbg_state  = state_q;

`ifdef RAM8_RDR_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + dout_q;
        end
    end

    assign bus.sum = sum_q;
`endif

endmodule

// File: tb/tb_ram8_burst_reader.sv
// Bench for ram8_burst_reader with a behavioural ram8 and a burst reference model;
// sum checks are active when RAM8_RDR_CHECKSUM_EN is defined.
module tb_ram8_burst_reader;
    import ram8_rdr_pkg::*;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram8_burst_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    ram8_burst_reader #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] mem [8];
    assign bus.mem_o = mem[bus.mem_add];

    int checks = 0;
    int errors = 0;

    // Reference model output
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_sum;

    // Observations of one burst
    logic [WIDTH-1:0] got_q[$];
    int               got_cyc[$];
    int               done_cyc, done_cnt, valid_cnt;
    bit               busy_bad, load_bad, hold_bad;
    logic             busy_after, done_after;
    logic [AW-1:0]    madd_at_done;
    logic [WIDTH-1:0] sum_at_done;
    logic             rs_valid, rs_busy, rs_done;
    logic [WIDTH-1:0] rs_dout, rs_sum;
    logic [AW-1:0]    rs_madd;
    state_t           rs_state;

    task automatic preload_ramp();
        for (int a = 0; a < 8; a++) mem[a] = WIDTH'(a * 123);
    endtask

    task automatic model_burst(input int b, input int l);
        int n;
        n = (l > 8) ? 8 : l;
        exp_q.delete();
        exp_sum = '0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mem[(b + k) % 8]);
            exp_sum = exp_sum + mem[(b + k) % 8];
        end
    endtask

    task automatic run_burst(input int b, input int l, input int stall_from, input int stall_n,
                             input bit rnd_ready, input int start2_cyc, input int rst_cyc,
                             input int max_cyc);
        logic             prev_stall;
        logic [WIDTH-1:0] prev_dout;
        got_q.delete();
        got_cyc.delete();
        done_cyc = -1; done_cnt = 0; valid_cnt = 0;
        busy_bad = 0; load_bad = 0; hold_bad = 0;
        busy_after = 1'bx; done_after = 1'bx; madd_at_done = 'x; sum_at_done = 'x;
        prev_stall = 1'b0; prev_dout = '0;
        bus.base = AW'(b); bus.len = 4'(l); bus.start = 1'b1; bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.base = AW'($urandom);
        bus.len = 4'($urandom);
        for (int c = 1; c <= max_cyc; c++) begin
            if (c >= stall_from && c < stall_from + stall_n) bus.dout_ready = 1'b0;
            else if (rnd_ready) bus.dout_ready = 1'($urandom_range(0, 1));
            else bus.dout_ready = 1'b1;
            bus.start = (c == start2_cyc);
            rst = (c == rst_cyc);
            @(negedge clk);
            if (bus.mem_load !== 1'b0) load_bad = 1;
            if (!(rst_cyc > 0 && c > rst_cyc)) begin
                if (done_cyc < 0 && bus.busy !== 1'b1) busy_bad = 1;
                if (prev_stall && (bus.dout_valid !== 1'b1 || bus.dout !== prev_dout)) hold_bad = 1;
            end
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                rs_valid = bus.dout_valid; rs_busy = bus.busy; rs_done = bus.done;
                rs_dout = bus.dout; rs_madd = bus.mem_add; rs_state = bus.dbg_state;
`ifdef RAM8_RDR_CHECKSUM_EN
                rs_sum = bus.sum;
`else
                rs_sum = '0;
`endif
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = bus.busy;
                done_after = bus.done;
            end
            if (bus.dout_valid === 1'b1) valid_cnt++;
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                got_q.push_back(bus.dout);
                got_cyc.push_back(c);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    madd_at_done = bus.mem_add;
`ifdef RAM8_RDR_CHECKSUM_EN
                    sum_at_done = bus.sum;
`endif
                end
            end
            prev_stall = (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b0);
            prev_dout = bus.dout;
            @(posedge clk); #1;
            if (done_cyc >= 0 && c == done_cyc + 1) break;
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.dout_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %0d exp 0", bus.dout); end
        checks++; if (bus.mem_add !== '0) begin errors++; $display("FAIL reset_mem_add got %0d exp 0", bus.mem_add); end
        checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE); end
`ifdef RAM8_RDR_CHECKSUM_EN
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got %0d exp 0", bus.sum); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input string tag);
        logic [WIDTH-1:0] lit [3];
        lit[0] = 16'd246; lit[1] = 16'd369; lit[2] = 16'd492;
        preload_ramp();
        model_burst(2, 3);
        run_burst(2, 3, 0, 0, 1'b0, 0, 0, 40);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL %s_count got %0d exp 3", tag, got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== lit[k] || got_q[k] !== exp_q[k]) begin errors++; $display("FAIL %s_word%0d got %0d exp %0d", tag, k, got_q[k], lit[k]); end
            checks++; if (got_cyc[k] != 2 * k + 2) begin errors++; $display("FAIL %s_cycle%0d got %0d exp %0d", tag, k, got_cyc[k], 2 * k + 2); end
        end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL %s_done_cycle got %0d exp 7", tag, done_cyc); end
        checks++; if (done_cnt != 1 || done_after !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %0d exp 1", tag, done_cnt); end
        checks++; if (busy_bad || busy_after !== 1'b0) begin errors++; $display("FAIL %s_busy got bad=%0d after=%b exp 0/0", tag, busy_bad, busy_after); end
        checks++; if (load_bad) begin errors++; $display("FAIL %s_mem_load got 1 exp 0", tag); end
        checks++; if (madd_at_done !== '0) begin errors++; $display("FAIL %s_mem_add_done got %0d exp 0", tag, madd_at_done); end
    endtask

    task automatic test_wrap();
        preload_ramp();
        model_burst(6, 4);
        run_burst(6, 4, 0, 0, 1'b0, 0, 0, 40);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL wrap_word%0d got %0d exp %0d", k, got_q[k], exp_q[k]); end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 9", done_cyc); end
`ifdef RAM8_RDR_CHECKSUM_EN
        checks++; if (sum_at_done !== 16'd1722) begin errors++; $display("FAIL wrap_sum got %0d exp 1722", sum_at_done); end
`endif
    endtask

    task automatic test_len0();
        run_burst($urandom_range(0, 7), 0, 0, 0, 1'b0, 0, 0, 20);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL len0_done_cycle got %0d exp 1", done_cyc); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL len0_valid got %0d exp 0", valid_cnt); end
        checks++; if (done_cnt != 1 || busy_after !== 1'b0) begin errors++; $display("FAIL len0_done_pulse got %0d exp 1", done_cnt); end
    endtask

    task automatic test_len_clamp();
        int b;
        b = $urandom_range(0, 7);
        preload_ramp();
        model_burst(b, 12);
        run_burst(b, 12, 0, 0, 1'b0, 0, 0, 60);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL clamp_count got %0d exp 8", got_q.size()); end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL clamp_word%0d got %0d exp %0d", k, got_q[k], exp_q[k]); end
        end
        checks++; if (done_cyc != 17) begin errors++; $display("FAIL clamp_done_cycle got %0d exp 17", done_cyc); end
    endtask

    task automatic test_backpressure();
        int b;
        b = $urandom_range(0, 7);
        preload_ramp();
        model_burst(b, 4);
        run_burst(b, 4, 2, 5, 1'b0, 0, 0, 60);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k] || got_cyc[k] != 2 * k + 7) begin errors++; $display("FAIL stall_word%0d got %0d@%0d exp %0d@%0d", k, got_q[k], got_cyc[k], exp_q[k], 2 * k + 7); end
        end
        checks++; if (hold_bad) begin errors++; $display("FAIL stall_hold got unstable exp stable"); end
        checks++; if (done_cyc != 14) begin errors++; $display("FAIL stall_done_cycle got %0d exp 14", done_cyc); end
    endtask

    task automatic test_start_ignored();
        preload_ramp();
        model_burst(1, 5);
        run_burst(1, 5, 0, 0, 1'b0, 3, 0, 60);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL restart_count got %0d exp 5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL restart_word%0d got %0d exp %0d", k, got_q[k], exp_q[k]); end
        end
        checks++; if (done_cyc != 11 || done_cnt != 1) begin errors++; $display("FAIL restart_done got %0d@%0d exp 1@11", done_cnt, done_cyc); end
    endtask

    task automatic test_reset_mid();
        preload_ramp();
        run_burst(0, 5, 0, 0, 1'b0, 0, 6, 14);
        checks++; if (rs_valid !== 1'b0 || rs_busy !== 1'b0 || rs_done !== 1'b0) begin errors++; $display("FAIL midrst_flags got v%b b%b d%b exp 000", rs_valid, rs_busy, rs_done); end
        checks++; if (rs_dout !== '0 || rs_madd !== '0) begin errors++; $display("FAIL midrst_data got dout %0d add %0d exp 0 0", rs_dout, rs_madd); end
        checks++; if (rs_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state got %0d exp %0d", rs_state, ST_IDLE); end
        checks++; if (rs_sum !== '0) begin errors++; $display("FAIL midrst_sum got %0d exp 0", rs_sum); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt); end
        test_basic("after_rst");
    endtask

    task automatic test_random();
        int b, l, n;
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < 8; a++) mem[a] = WIDTH'($urandom);
            b = $urandom_range(0, 7);
            l = $urandom_range(0, 15);
            n = (l > 8) ? 8 : l;
            model_burst(b, l);
            run_burst(b, l, 0, 0, 1'b1, 0, 0, 300);
            checks++; if (got_q.size() != n) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), n); end
            for (int k = 0; k < n && k < got_q.size(); k++) begin
                checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_word%0d got %0d exp %0d", it, k, got_q[k], exp_q[k]); end
            end
            checks++; if (done_cnt != 1 || hold_bad || busy_bad || load_bad) begin errors++; $display("FAIL rand%0d_ctrl got done=%0d hold=%0d busy=%0d load=%0d exp 1 0 0 0", it, done_cnt, hold_bad, busy_bad, load_bad); end
`ifdef RAM8_RDR_CHECKSUM_EN
            checks++; if (sum_at_done !== exp_sum) begin errors++; $display("FAIL rand%0d_sum got %0d exp %0d", it, sum_at_done, exp_sum); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_wrap();
        test_len0();
        test_len_clamp();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
